heap_cmd_sequencer: RTL and testbench

- Upstream command front-end for heap_control. Accepts push/pop commands on a valid/ready stream and buffers them in a small FIFO.
- Issues commands one at a time as start/op/key pulses and waits for done. Returns exactly one response per command on a valid/ready response stream.
- Guards against pop-on-empty, push-on-full and a hung heap engine.

---
 rtl/heap_cmd_sequencer_if.sv | 31 +++
 rtl/heap_cmd_sequencer.sv | 130 +++++++++++++
 tb/tb_heap_cmd_sequencer.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/heap_cmd_sequencer_if.sv
// rtl/heap_cmd_sequencer_if.sv - command, response and heap_control signal bundle for heap_cmd_sequencer
interface heap_cmd_sequencer_if #(
    parameter int KEY_W = 32,
    parameter int N_W   = 10
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_op;
    logic [KEY_W-1:0] cmd_key;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [KEY_W-1:0] rsp_data;
    logic             rsp_err;
    logic             heap_start;
    logic             heap_op;
    logic [KEY_W-1:0] heap_key;
    logic             heap_done;
    logic [KEY_W-1:0] heap_top;
    logic [N_W-1:0]   heap_n;

    // slave = the sequencer, master = whoever drives commands and models the heap
    modport slave (
        input  cmd_valid, cmd_op, cmd_key, rsp_ready, heap_done, heap_top, heap_n,
        output cmd_ready, rsp_valid, rsp_data, rsp_err, heap_start, heap_op, heap_key
    );

    modport master (
        output cmd_valid, cmd_op, cmd_key, rsp_ready, heap_done, heap_top, heap_n,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err, heap_start, heap_op, heap_key
    );
endinterface

// File: rtl/heap_cmd_sequencer.sv
// rtl/heap_cmd_sequencer.sv - buffers push/pop commands and sequences them one at a time into heap_control
module heap_cmd_sequencer #(
    parameter int KEY_W      = 32,
    parameter int N_W        = 10,
    parameter int CAP        = 1023,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 4095
) (
    input  logic                 clk,
    input  logic                 reset,
    heap_cmd_sequencer_if.slave  bus,
    output logic                 busy
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, CHECK, ISSUE, WAIT, RESP} state_t;

    state_t           state, state_nx;
    logic [KEY_W-1:0] fifo_key [FIFO_DEPTH];
    logic             fifo_op  [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;
    logic             full, empty, fifo_wr, fifo_rd;
    logic             head_op;
    logic [KEY_W-1:0] head_key;
    logic             reject, done_ok, tcnt_last;
    logic             op_q;
    logic [KEY_W-1:0] key_q;
    logic [KEY_W-1:0] rsp_data_q;
    logic             rsp_err_q;
    logic [TW-1:0]    tcnt;

    assign full     = (count == CW'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign fifo_wr  = bus.cmd_valid & ~full;
    assign fifo_rd  = (state == CHECK);
    assign head_op  = fifo_op[rd_ptr];
    assign head_key = fifo_key[rd_ptr];

    assign reject    = head_op ? (bus.heap_n == '0) : (bus.heap_n == N_W'(CAP));
    // done may still be high from the previous op during the first WAIT cycle
    assign done_ok   = (tcnt != '0) & bus.heap_done;
    assign tcnt_last = (tcnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            fifo_key[wr_ptr] <= bus.cmd_key;
            fifo_op[wr_ptr]  <= bus.cmd_op;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (fifo_wr) wr_ptr <= wr_ptr + 1'b1;
            if (fifo_rd) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(fifo_wr) - CW'(fifo_rd);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (!empty) state_nx = CHECK;
            CHECK:   state_nx = reject ? RESP : ISSUE;
            ISSUE:   state_nx = WAIT;
            WAIT:    if (done_ok || tcnt_last) state_nx = RESP;
            RESP:    if (bus.rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q       <= 1'b0;
            key_q      <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            tcnt       <= '0;
        end else begin
            case (state)
                CHECK: begin
                    op_q       <= head_op;
                    key_q      <= head_key;
                    rsp_data_q <= head_op ? '0 : head_key;
                    rsp_err_q  <= reject;
                end
                ISSUE: begin
                    tcnt <= '0;
                    // pre-pop root: heap_control has not started modifying arr[0] yet
                    if (op_q) rsp_data_q <= bus.heap_top;
                end
                WAIT: begin
                    tcnt <= tcnt + 1'b1;
                    if (!done_ok && tcnt_last) begin
                        rsp_data_q <= '1;
                        rsp_err_q  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.heap_start = (state == ISSUE);
        bus.heap_op    = 1'b0;
        bus.heap_key   = '0;
        if (state == ISSUE || state == WAIT) begin
            bus.heap_op  = op_q;
            bus.heap_key = key_q;
        end
        bus.rsp_valid = (state == RESP);
        busy          = (state != IDLE) | ~empty;
    end

    assign bus.cmd_ready = ~full;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_heap_cmd_sequencer.sv
// tb/tb_heap_cmd_sequencer.sv - directed self-checking bench for heap_cmd_sequencer
module tb_heap_cmd_sequencer;
    logic clk = 1'b0;
    logic reset;
    logic busy;
    int   checks = 0;
    int   errors = 0;

    heap_cmd_sequencer_if #(.KEY_W(32), .N_W(10)) bus ();

    heap_cmd_sequencer #(
        .KEY_W(32), .N_W(10), .CAP(1023), .FIFO_DEPTH(4), .TIMEOUT(4095)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    // heap_control stand-in: done drops on start and rises two cycles later
    logic done_q = 1'b0;
    int   dcnt   = 0;
    logic hang   = 1'b0;
    logic stale  = 1'b0;
    assign bus.heap_done = done_q;

    always @(posedge clk) begin
        if (bus.heap_start) begin
            if (!stale) done_q <= 1'b0;
            dcnt <= 2;
        end else if (dcnt > 0) begin
            dcnt <= dcnt - 1;
            if (dcnt == 1 && !hang) done_q <= 1'b1;
        end
    end

    int          starts = 0;
    logic [31:0] rsp_d_log[$];
    logic        rsp_e_log[$];
    int          rd_idx = 0;

    always @(posedge clk) begin
        if (bus.heap_start) starts = starts + 1;
        if (bus.rsp_valid && bus.rsp_ready) begin
            rsp_d_log.push_back(bus.rsp_data);
            rsp_e_log.push_back(bus.rsp_err);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic op, input logic [31:0] key);
        int n = 0;
        bus.cmd_op    = op;
        bus.cmd_key   = key;
        bus.cmd_valid = 1'b1;
        while (!bus.cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_accept", bus.cmd_ready, 1);
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic get_rsp(input logic [31:0] d, input logic e, input string tag);
        int n = 0;
        while (rsp_d_log.size() <= rd_idx && n < 10000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_got"}, rsp_d_log.size() > rd_idx, 1);
        if (rsp_d_log.size() > rd_idx) begin
            chk({tag, "_data"}, rsp_d_log[rd_idx], d);
            chk({tag, "_err"}, rsp_e_log[rd_idx], e);
            rd_idx++;
        end
    endtask

    task automatic run_cmd(input logic op, input logic [31:0] key, input string tag);
        int   s0 = starts;
        int   n = 0;
        logic inflight = 1'b0;
        logic stable = 1'b1;
        send(op, key);
        while (rsp_d_log.size() <= rd_idx && n < 100) begin
            if (bus.heap_start) inflight = 1'b1;
            if (bus.rsp_valid) inflight = 1'b0;
            if (inflight && (bus.heap_op !== op || bus.heap_key !== key)) stable = 1'b0;
            @(negedge clk);
            n++;
        end
        chk({tag, "_stable"}, stable, 1);
        chk({tag, "_starts"}, starts - s0, 1);
    endtask

    task automatic wait_start(input string tag);
        int n = 0;
        while (!bus.heap_start && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_start"}, bus.heap_start, 1);
    endtask

    initial begin
        int   s0;
        int   lat;
        logic stray;

        reset         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 1'b0;
        bus.cmd_key   = '0;
        bus.rsp_ready = 1'b0;
        bus.heap_top  = 32'd20;
        bus.heap_n    = 10'd10;
        #1;
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_heap_start", bus.heap_start, 0);
        chk("rst_rsp_err", bus.rsp_err, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        bus.rsp_ready = 1'b1;
        @(negedge clk);

        // push then pop against n=10, root=20
        run_cmd(1'b0, 32'd15, "push15");
        get_rsp(32'd15, 1'b0, "push15");
        run_cmd(1'b1, 32'd0, "pop");
        get_rsp(32'd20, 1'b0, "pop");

        // pop on empty heap
        bus.heap_n = 10'd0;
        s0 = starts;
        send(1'b1, 32'd0);
        lat = 0;
        while (!bus.rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("pop_empty_latency", lat, 2);
        get_rsp(32'd0, 1'b1, "pop_empty");
        chk("pop_empty_nostart", starts - s0, 0);

        // push on full heap
        bus.heap_n = 10'd1023;
        s0 = starts;
        send(1'b0, 32'd7);
        get_rsp(32'd7, 1'b1, "push_full");
        chk("push_full_nostart", starts - s0, 0);
        bus.heap_n = 10'd10;

        // backpressure: 4 buffered + 1 in flight fills the sequencer
        bus.rsp_ready = 1'b0;
        s0 = starts;
        for (int i = 0; i < 5; i++) send(1'b0, 32'd101 + i);
        chk("bp_full", bus.cmd_ready, 0);
        chk("bp_busy", busy, 1);
        repeat (5) @(negedge clk);
        chk("bp_no_rsp", rsp_d_log.size() - rd_idx, 0);
        chk("bp_still_full", bus.cmd_ready, 0);
        bus.rsp_ready = 1'b1;
        send(1'b0, 32'd106);
        for (int i = 0; i < 6; i++) get_rsp(32'd101 + i, 1'b0, "bp_order");
        lat = 0;
        while (busy && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk("bp_idle", busy, 0);
        chk("bp_starts", starts - s0, 6);

        // stale done held high through ISSUE
        stale = 1'b1;
        send(1'b0, 32'd55);
        wait_start("stale");
        repeat (2) @(negedge clk);
        chk("stale_first_wait", bus.rsp_valid, 0);
        @(negedge clk);
        chk("stale_second_wait", bus.rsp_valid, 1);
        get_rsp(32'd55, 1'b0, "stale");
        stale = 1'b0;

        // hung engine: timeout after 4095 WAIT cycles
        hang = 1'b1;
        send(1'b0, 32'd77);
        wait_start("timeout");
        lat = 0;
        while (!bus.rsp_valid && lat < 5000) begin
            @(negedge clk);
            lat++;
        end
        chk("timeout_cycles", lat, 4096);
        get_rsp(32'hFFFF_FFFF, 1'b1, "timeout");
        hang = 1'b0;
        send(1'b0, 32'd78);
        get_rsp(32'd78, 1'b0, "after_timeout");

        // async reset in the middle of WAIT
        hang = 1'b1;
        send(1'b0, 32'd99);
        wait_start("rst_wait");
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("mid_cmd_ready", bus.cmd_ready, 1);
        chk("mid_rsp_valid", bus.rsp_valid, 0);
        chk("mid_busy", busy, 0);
        chk("mid_heap_start", bus.heap_start, 0);
        chk("mid_heap_op", bus.heap_op, 0);
        chk("mid_heap_key", bus.heap_key, 0);
        chk("mid_rsp_data", bus.rsp_data, 0);
        chk("mid_rsp_err", bus.rsp_err, 0);
        @(negedge clk);
        reset = 1'b1;
        hang  = 1'b0;
        stray = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (bus.rsp_valid) stray = 1'b1;
        end
        chk("mid_no_stray", stray, 0);
        chk("mid_no_rsp", rsp_d_log.size() - rd_idx, 0);
        run_cmd(1'b1, 32'd0, "post_rst_pop");
        get_rsp(32'd20, 1'b0, "post_rst_pop");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end
endmodule
